// File: rtl/four_bit_full_adder.sv
// Registered 4-bit ripple-carry adder slice with carry-in/out.
// Result {c4, s} appears one cycle after a qualified capture.
module four_bit_full_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output logic       out_valid
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] sum;
  logic [4:0] c;

  assign c[0] = c0;

  // One full-adder cell per bit; carry ripples c[0] -> c[4].
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign g[i]   = a[i] & b[i];
    assign p[i]   = a[i] ^ b[i];
    assign sum[i] = p[i] ^ c[i];
    assign c[i+1] = g[i] | (c[i] & p[i]);
  end

  // Operands are only sampled under in_valid, so X/Z while idle is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= 4'b0000;
      c4        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s  <= sum;
        c4 <= c[4];
      end
    end
  end

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed and exhaustive bench for four_bit_full_adder.
// Inputs change on falling edges; outputs sampled 1ns after rising edges.
module tb_four_bit_full_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       c0;
  logic [3:0] s;
  logic       c4;
  logic       out_valid;

  int n_cmp;
  int n_err;

  logic [3:0] va [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd13,
                          4'd7, 4'd15, 4'd9, 4'd12, 4'd15, 4'd9};
  logic [3:0] vb [12] = '{4'd0, 4'd1, 4'd1, 4'd4, 4'd1, 4'd1,
                          4'd7, 4'd15, 4'd8, 4'd10, 4'd15, 4'd9};
  logic       vc [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [4:0] ve [12] = '{5'd0, 5'd2, 5'd3, 5'd7, 5'd6, 5'd14,
                          5'd15, 5'd31, 5'd17, 5'd22, 5'd30, 5'd18};

  four_bit_full_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .s         (s),
    .c4        (c4),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] ai,
                       input logic [3:0] bi, input logic ci);
    @(negedge clk);
    in_valid = v;
    a        = ai;
    b        = bi;
    c0       = ci;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    c0       = 1'b0;
    #3;
    n_cmp++;
    if ({out_valid, c4, s} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_init: got v=%b c4=%b s=%0d want 0/0/0",
               out_valid, c4, s);
    end
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, c4, s} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_hold_init: got v=%b c4=%b s=%0d want 0/0/0",
               out_valid, c4, s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, c4, s} !== {1'b1, 5'd31}) begin
      n_err++;
      $display("FAIL reset_first: got v=%b c4=%b s=%0d want 1/1/15",
               out_valid, c4, s);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 4'd12, 4'd10, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, c4, s} !== {1'b1, 5'd22}) begin
      n_err++;
      $display("FAIL pre_reset: got v=%b c4=%b s=%0d want 1/1/6",
               out_valid, c4, s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, c4, s} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b c4=%b s=%0d want 0/0/0",
               out_valid, c4, s);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, c4, s} !== 6'd0) begin
        n_err++;
        $display("FAIL reset_hold: got v=%b c4=%b s=%0d want 0/0/0",
                 out_valid, c4, s);
      end
    end
    drive(1'b1, 4'd9, 4'd9, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, c4, s} !== {1'b1, 5'd18}) begin
      n_err++;
      $display("FAIL reset_release: got v=%b c4=%b s=%0d want 1/1/2",
               out_valid, c4, s);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, c4, s} !== {1'b1, ve[i]}) begin
        n_err++;
        $display("FAIL basic[%0d]: got v=%b sum=%0d want v=1 sum=%0d",
                 i, out_valid, {c4, s}, ve[i]);
      end
      drive(1'b0, 4'd0, 4'd0, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, c4, s} !== {1'b0, ve[i]}) begin
        n_err++;
        $display("FAIL basic_idle[%0d]: got v=%b sum=%0d want v=0 sum=%0d",
                 i, out_valid, {c4, s}, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, c4, s} !== {1'b1, ve[i]}) begin
        n_err++;
        $display("FAIL stream[%0d]: got v=%b sum=%0d want v=1 sum=%0d",
                 i, out_valid, {c4, s}, ve[i]);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b1, 4'd13, 4'd1, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, c4, s} !== {1'b1, 5'd14}) begin
      n_err++;
      $display("FAIL hold_load: got v=%b sum=%0d want v=1 sum=14",
               out_valid, {c4, s});
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'(i * 5 + 3), 4'(15 - i), 1'b1);
      if (i == 2) begin
        a  = 4'bxxzz;
        b  = 4'bzzxx;
        c0 = 1'bx;
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, c4, s} !== {1'b0, 5'd14}) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%b sum=%0d want v=0 sum=14",
                 i, out_valid, {c4, s});
      end
    end
  endtask

  task automatic test_exhaustive;
    logic [4:0] exp_sum;
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i));
      exp_sum = 5'(i >> 5) + 5'((i >> 1) & 15) + 5'(i & 1);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, c4, s} !== {1'b1, exp_sum}) begin
        n_err++;
        $display("FAIL exh a=%0d b=%0d c0=%0d: got v=%b sum=%0d want v=1 sum=%0d",
                 i >> 5, (i >> 1) & 15, i & 1, out_valid, {c4, s}, exp_sum);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    test_exhaustive;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/four_bit_full_adder.md
# four_bit_full_adder

Registered 4-bit binary adder with carry-in and carry-out, used as the basic arithmetic slice of the MIPS datapath. It can be cascaded through `c0`/`c4` to build wider adders. Each operand pair with its carry-in is captured on a clock edge. The 5-bit result `{c4, s}` is presented from an output register one cycle later.

## Interface
- No parameters; width fixed at 4 bits.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  qualifies `a`, `b`, `c0` for capture this cycle.
- `a`  input  4  addend A, unsigned.
- `b`  input  4  addend B, unsigned.
- `c0`  input  1  carry-in, bit weight 1.
- `s`  output  4  sum bits, registered.
- `c4`  output  1  carry-out, weight 16, registered.
- `out_valid`  output  1  high for one cycle when `s`/`c4` hold a new result.

## Operation
- Arithmetic: `{c4, s} = a + b + c0`, computed exactly in 5 bits; range 0..31; no truncation, no saturation.
- Datapath structure:
  - four 1-bit full-adder cells: `s_i = a_i ^ b_i ^ c_i`, `c_{i+1} = a_i&b_i | c_i&(a_i^b_i)`;
  - carry chain from `c0` to `c4`;
  - per-bit generate `g_i = a_i&b_i` and propagate `p_i = a_i^b_i` exposed internally;
  - lookahead form is permitted if results are bit-identical.
- Unsigned interpretation only. No overflow flag: signed overflow is the caller's job (`c3 ^ c4`) and is not an output.
- Capture:
  - on a rising edge with `in_valid=1` and `rst_n=1`, the combinational sum of the current inputs is loaded into the `s`/`c4` registers and `out_valid` is set to 1;
  - on an edge with `in_valid=0`, `s`/`c4` hold their previous value and `out_valid` goes to 0.
- X/Z on inputs when `in_valid=0` must not disturb outputs.
- Back-to-back operation: a new operand pair every cycle is supported, with no bubbles and no stall.

## Timing
- Latency: result for inputs sampled at edge N is visible on `s`/`c4`/`out_valid` after edge N, i.e. through cycle N+1. Throughput is 1 result/cycle.
- Reset, on `rst_n` going low, takes effect immediately, independent of `clk`:
  - `s = 4'b0000`, `c4 = 0`, `out_valid = 0`.
- Reset mid-operation: any in-flight result is discarded. The first edge with `rst_n=1` and `in_valid=1` produces the first valid result.
- Reset release is synchronous-safe: deassertion is sampled at the next rising edge.
- Combinational path `a`/`b`/`c0` → register D must close within one clock period; the ripple path is the critical path (4 carry stages).
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst_n=0` mid-cycle with nonzero outputs → `s=0`, `c4=0`, `out_valid=0` immediately, without waiting for a clock edge; they hold through edges while reset is low.
- Basic, no carry-out:
  - a=0,b=0,c0=0 → s=0,c4=0;
  - a=1,b=1,c0=0 → s=2,c4=0;
  - a=2,b=1,c0=0 → s=3,c4=0;
  - a=3,b=4,c0=0 → s=7,c4=0;
  - a=5,b=1,c0=0 → s=6,c4=0;
  - a=13,b=1,c0=0 → s=14,c4=0.
- Carry-in boundary: a=7,b=7,c0=1 → s=15,c4=0 (max without carry-out); a=15,b=15,c0=1 → s=15,c4=1 (max result 31).
- Carry-out cases:
  - a=9,b=8,c0=0 → s=1,c4=1;
  - a=12,b=10,c0=0 → s=6,c4=1;
  - a=15,b=15,c0=0 → s=14,c4=1;
  - a=9,b=9,c0=0 → s=2,c4=1.
- Streaming: apply the above vectors on consecutive cycles with `in_valid=1` → each result appears exactly one cycle after its inputs, `out_valid` stays high continuously.
- Hold: `in_valid=0` for 3 cycles with changing a/b → `s`/`c4` unchanged, `out_valid=0`.
- Exhaustive: all 512 combinations of a, b, c0 → `{c4,s}` equals the reference sum.
